// File: rtl/note_period_detector_if.sv
// Tone-side and note-ROM-side signals of the note period detector.
interface note_period_detector_if;
  logic        tone_in;
  logic [15:0] rom_data;
  logic [5:0]  rom_addr;
  logic [5:0]  note;
  logic        note_valid;
  logic        no_tone;

  // master: tone source, note ROM and note consumer; slave: the detector
  modport master (
    output tone_in,
    output rom_data,
    input  rom_addr,
    input  note,
    input  note_valid,
    input  no_tone
  );

  modport slave (
    input  tone_in,
    input  rom_data,
    output rom_addr,
    output note,
    output note_valid,
    output no_tone
  );
endinterface

// File: rtl/note_period_detector.sv
// Measures tone edge spacing and searches a note ROM for the closest entry;
// NOTE_VALID lands 65 cycles after the measuring edge is registered, no backpressure.
module note_period_detector #(
  parameter int unsigned TOL_SHIFT = 3,
  parameter logic [15:0] MIN_COUNT = 16'h0010,
  parameter logic [15:0] TIMEOUT   = 16'h1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  note_period_detector_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;

  logic        sync1, sync2, sync3;
  logic        tone_edge;
  logic [15:0] counter;
  logic        armed;
  logic [1:0]  state;
  logic [15:0] meas;
  logic [15:0] best_diff;
  logic [5:0]  best_idx;
  logic [5:0]  rom_addr;
  logic [5:0]  note;
  logic        note_valid;
  logic        no_tone;

  logic        timeout_hit;
  logic        candidate;
  logic [15:0] diff;
  logic [15:0] tol;

  assign timeout_hit = (counter == TIMEOUT) && !tone_edge;
  // Edges that arrive while a search is running are only used to restart the counter.
  assign candidate   = tone_edge && armed && (counter >= MIN_COUNT) && (state == IDLE);
  assign diff        = (bus.rom_data >= meas) ? (bus.rom_data - meas) : (meas - bus.rom_data);
  assign tol         = meas >> TOL_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      tone_edge <= 1'b0;
    end else begin
      sync1     <= bus.tone_in;
      sync2     <= sync1;
      sync3     <= sync2;
      tone_edge <= sync2 ^ sync3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= 16'd0;
    end else if (tone_edge) begin
      counter <= 16'd1;
    end else if (counter != 16'hFFFF) begin
      counter <= counter + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      no_tone <= 1'b1;
    end else if (timeout_hit) begin
      armed   <= 1'b0;
      no_tone <= 1'b1;
    end else if (tone_edge) begin
      armed   <= 1'b1;
      no_tone <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      meas       <= 16'd0;
      best_diff  <= 16'd0;
      best_idx   <= 6'd0;
      rom_addr   <= 6'd0;
      note       <= 6'd0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      // A timeout wins over everything, including a search finishing this cycle.
      if (timeout_hit) begin
        state    <= IDLE;
        rom_addr <= 6'd0;
        note     <= 6'd0;
      end else begin
        case (state)
          IDLE: begin
            rom_addr <= 6'd0;
            if (candidate) begin
              meas      <= counter;
              best_diff <= 16'hFFFF;
              best_idx  <= 6'd0;
              rom_addr  <= 6'd1;
              state     <= SEARCH;
            end
          end
          SEARCH: begin
            // 16'hFFFF marks a silent slot that must never win.
            if ((bus.rom_data != 16'hFFFF) && (diff < best_diff)) begin
              best_diff <= diff;
              best_idx  <= rom_addr;
            end
            if (rom_addr == 6'd63) begin
              rom_addr <= 6'd0;
              state    <= DECIDE;
            end else begin
              rom_addr <= rom_addr + 6'd1;
            end
          end
          DECIDE: begin
            if ((best_idx != 6'd0) && (best_diff <= tol)) begin
              note       <= best_idx;
              note_valid <= 1'b1;
            end
            state <= IDLE;
          end
          default: begin
            state    <= IDLE;
            rom_addr <= 6'd0;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.note       = note;
  assign bus.note_valid = note_valid;
  assign bus.no_tone    = no_tone;

endmodule

// File: tb/tb_note_period_detector.sv
// Directed bench for note_period_detector: table of tone spacings plus
// hand-written sequences for reset, continuous tone, timeout and mid-search reset.
module tb_note_period_detector;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  note_period_detector_if bus();

  logic [15:0] rom [64];
  assign bus.rom_data = rom[bus.rom_addr];

  note_period_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int spacing;
    int exp_pulses;
    int exp_note;
    int exp_max_addr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.tone_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic watch(input int n, output int pulses, output int first,
                       output int max_addr, output int dbl);
    logic prev;
    pulses   = 0;
    first    = -1;
    max_addr = 0;
    dbl      = 0;
    prev     = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (bus.note_valid) begin
        if (prev) dbl++;
        if (pulses == 0) first = i;
        pulses++;
      end
      prev = bus.note_valid;
      if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
    end
  endtask

  initial begin
    int   pulses, first, max_addr, dbl;
    int   pq [$];
    int   exp_pq [3];
    logic prev;
    real  r;

    // Equal-tempered half periods at 50 kHz, index 1 = 0x02FD, index 32 silent
    for (int i = 0; i < 64; i++) begin
      r = 765.0 / (2.0 ** ((i - 1) / 12.0));
      rom[i] = 16'($rtoi(r + 0.5));
    end
    rom[0]  = 16'hFFFF;
    rom[1]  = 16'h02FD;
    rom[31] = 16'h0087;
    rom[32] = 16'hFFFF;
    rom[33] = 16'h0078;
    rom[44] = 16'h0040;
    rom[45] = 16'h003C;
    rom[46] = 16'h0039;

    vecs[0] = '{spacing: 'h39,  exp_pulses: 1, exp_note: 'h2E, exp_max_addr: 63};
    vecs[1] = '{spacing: 'h3E,  exp_pulses: 1, exp_note: 'h2C, exp_max_addr: 63};
    vecs[2] = '{spacing: 'h80,  exp_pulses: 1, exp_note: 'h1F, exp_max_addr: 63};
    vecs[3] = '{spacing: 'h400, exp_pulses: 0, exp_note: 'h00, exp_max_addr: 63};
    vecs[4] = '{spacing: 'h08,  exp_pulses: 0, exp_note: 'h00, exp_max_addr: 0};

    // Reset held while the tone toggles
    bus.tone_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_no_tone", bus.no_tone, 1);
    for (int k = 0; k < 6; k++) begin
      bus.tone_in = ~bus.tone_in;
      step();
      check("rst_note",       bus.note, 0);
      check("rst_note_valid", bus.note_valid, 0);
      check("rst_no_tone",    bus.no_tone, 1);
      check("rst_rom_addr",   bus.rom_addr, 0);
    end
    bus.tone_in = 1'b1;
    rst_n = 1'b1;
    watch(80, pulses, first, max_addr, dbl);
    check("first_edge_no_pulse", pulses, 0);
    check("first_edge_clears_no_tone", bus.no_tone, 0);

    // Single measured interval after a fresh reset
    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.tone_in = 1'b1;
      repeat (vecs[v].spacing) step();
      bus.tone_in = 1'b0;
      watch(80, pulses, first, max_addr, dbl);
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      if (vecs[v].exp_pulses != 0)
        check($sformatf("vec%0d_latency", v), first, 68);
      check($sformatf("vec%0d_note", v), bus.note, vecs[v].exp_note);
      check($sformatf("vec%0d_max_addr", v), max_addr, vecs[v].exp_max_addr);
      check($sformatf("vec%0d_double", v), dbl, 0);
      check($sformatf("vec%0d_no_tone", v), bus.no_tone, 0);
    end

    // Continuous A4, a rejected long interval, timeout, then resume
    do_reset();
    bus.tone_in = ~bus.tone_in;
    prev = 1'b0;
    dbl  = 0;
    for (int i = 1; i <= 5600; i++) begin
      step();
      if (bus.note_valid) begin
        if (prev) dbl++;
        pq.push_back(i);
      end
      prev = bus.note_valid;
      if (i == 1340) check("hold_note_after_reject", bus.note, 'h2E);
      if (i == 5351) begin
        check("pre_timeout_no_tone", bus.no_tone, 0);
        check("pre_timeout_note", bus.note, 'h2E);
      end
      if (i == 5352) begin
        check("timeout_no_tone", bus.no_tone, 1);
        check("timeout_note", bus.note, 0);
      end
      if (i == 5410) check("resume_clears_no_tone", bus.no_tone, 0);
      if (i inside {57, 114, 171, 228, 1252, 5400, 5457}) bus.tone_in = ~bus.tone_in;
    end
    exp_pq[0] = 125;
    exp_pq[1] = 239;
    exp_pq[2] = 5525;
    check("stream_pulse_count", pq.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("stream_pulse%0d_time", k), (k < pq.size()) ? pq[k] : -1, exp_pq[k]);
    check("stream_double", dbl, 0);
    check("stream_final_note", bus.note, 'h2E);

    // Reset in the middle of a search
    do_reset();
    bus.tone_in = 1'b1;
    repeat (57) step();
    bus.tone_in = 1'b0;
    watch(80, pulses, first, max_addr, dbl);
    check("pre_abort_note", bus.note, 'h2E);
    bus.tone_in = 1'b1;
    repeat (35) step();
    check("abort_rom_addr_mid", bus.rom_addr, 'h20);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rom_addr", bus.rom_addr, 0);
    check("abort_note", bus.note, 0);
    check("abort_note_valid", bus.note_valid, 0);
    check("abort_no_tone", bus.no_tone, 1);
    bus.tone_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.tone_in = 1'b1;
    pq.delete();
    for (int i = 1; i <= 137; i++) begin
      step();
      if (bus.note_valid) pq.push_back(i);
      if (i == 57) bus.tone_in = 1'b0;
    end
    check("post_abort_pulse_count", pq.size(), 1);
    check("post_abort_pulse_time", (pq.size() > 0) ? pq[0] : -1, 125);
    check("post_abort_note", bus.note, 'h2E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
